// File: rtl/pwr_pkg.sv
// Shared power-mode encodings and default window lengths, so every consumer of
// pwr_state decodes it the same way.
package pwr_pkg;

  typedef enum logic [1:0] {
    PWR_SLEEP = 2'b00,
    PWR_WAKE  = 2'b01,
    PWR_RUN   = 2'b10,
    PWR_IDLE  = 2'b11
  } pwr_state_e;

  localparam int unsigned PWR_IDLE_CYCLES_DEF = 8;
  localparam int unsigned PWR_WAKE_CYCLES_DEF = 3;
  localparam int unsigned PWR_CNT_W_DEF       = 8;

endpackage

// File: rtl/pwr_cycle_timer.sv
// Clearable up-counter with a runtime terminal value; it holds at the terminal
// value instead of wrapping.
module pwr_cycle_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic [CNT_W-1:0] term_i,
  output logic             tc_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tc_o = (cnt_q == term_i);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !tc_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pwr_mode_ctrl.sv
// Activity-driven power-mode controller: gates the downstream clock after an idle
// timeout and restarts it through a fixed warm-up window.
module pwr_mode_ctrl
  import pwr_pkg::*;
#(
  parameter int unsigned IDLE_CYCLES = PWR_IDLE_CYCLES_DEF,
  parameter int unsigned WAKE_CYCLES = PWR_WAKE_CYCLES_DEF,
  parameter int unsigned CNT_W       = PWR_CNT_W_DEF
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       req_i,
  input  logic       sleep_req_i,
  output logic       enable_o,
  output logic       clk_gate_en_o,
  output logic       wake_ack_o,
  output logic [1:0] pwr_state_o
);

  localparam logic [CNT_W-1:0] WAKE_TERM = CNT_W'(WAKE_CYCLES - 1);
  localparam logic [CNT_W-1:0] IDLE_TERM = CNT_W'(IDLE_CYCLES - 1);

  pwr_state_e       state_q;
  pwr_state_e       state_d;
  logic             enable_q;
  logic             clk_gate_en_q;
  logic             wake_ack_q;
  logic             tmr_clr;
  logic             tmr_inc;
  logic             tmr_tc;
  logic [CNT_W-1:0] tmr_term;

  pwr_cycle_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (tmr_clr),
    .inc_i  (tmr_inc),
    .term_i (tmr_term),
    .tc_o   (tmr_tc)
  );

  // The timer is cleared on every transition so each window starts from zero.
  always_comb begin
    state_d  = state_q;
    tmr_clr  = 1'b1;
    tmr_inc  = 1'b0;
    tmr_term = (state_q == PWR_WAKE) ? WAKE_TERM : IDLE_TERM;
    case (state_q)
      PWR_SLEEP: begin
        if (req_i && !sleep_req_i) state_d = PWR_WAKE;
      end
      PWR_WAKE: begin
        if (sleep_req_i) begin
          state_d = PWR_SLEEP;
        end else if (tmr_tc) begin
          state_d = PWR_RUN;
        end else begin
          tmr_clr = 1'b0;
          tmr_inc = 1'b1;
        end
      end
      PWR_RUN: begin
        if (sleep_req_i)  state_d = PWR_SLEEP;
        else if (!req_i)  state_d = PWR_IDLE;
      end
      PWR_IDLE: begin
        if (sleep_req_i) begin
          state_d = PWR_SLEEP;
        end else if (req_i) begin
          state_d = PWR_RUN;
        end else if (tmr_tc) begin
          state_d = PWR_SLEEP;
        end else begin
          tmr_clr = 1'b0;
          tmr_inc = 1'b1;
        end
      end
      default: state_d = PWR_SLEEP;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= PWR_SLEEP;
      enable_q      <= 1'b0;
      clk_gate_en_q <= 1'b0;
      wake_ack_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      enable_q      <= (state_d == PWR_RUN);
      clk_gate_en_q <= (state_d != PWR_SLEEP);
      wake_ack_q    <= (state_q == PWR_WAKE) && (state_d == PWR_RUN);
    end
  end

  assign enable_o      = enable_q;
  assign clk_gate_en_o = clk_gate_en_q;
  assign wake_ack_o    = wake_ack_q;
  assign pwr_state_o   = state_q;

endmodule

// File: doc/pwr_mode_ctrl.md
Name: pwr_mode_ctrl

Overview:
- Activity-driven power-mode controller that sits directly upstream of the low-power FSM.
- Drives that FSM's `enable` input and the clock-gate enable for its clock domain.
- Stops the downstream FSM when activity stops and gates its clock after an idle timeout.
- Restarts it through a fixed clock warm-up window when activity returns, and gives an explicit wake acknowledge.

Parameters:
- IDLE_CYCLES, 8, cycles with req low in IDLE before entering SLEEP (must be >=1)
- WAKE_CYCLES, 3, cycles spent in WAKE with clock ungated before enable asserts (must be >=1)
- CNT_W, 8, shared cycle-counter width; must hold max(IDLE_CYCLES, WAKE_CYCLES)-1

Ports:
- clk  in  1  single system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req  in  1  level activity request from the producer
- sleep_req  in  1  forced-sleep request from the power manager, level
- enable  out  1  run enable to the downstream low-power FSM
- clk_gate_en  out  1  clock-gate enable for the downstream clock domain
- wake_ack  out  1  one-cycle pulse on the cycle enable first rises after WAKE
- pwr_state  out  2  current mode: 00 SLEEP, 01 WAKE, 10 RUN, 11 IDLE

Behaviour:
- Reset (reset=0, asynchronous): state=SLEEP, cnt=0. Outputs take these values without waiting for a clock:
  - enable=0, clk_gate_en=0, wake_ack=0, pwr_state=00.
- Output decode (all from registered state, no combinational path from inputs):
  - enable=1 only in RUN.
  - clk_gate_en=1 in WAKE, RUN and IDLE.
  - wake_ack is a registered flag: set on the WAKE->RUN transition, cleared on the following edge.
- Priority: sleep_req=1 beats req in every state.
- SLEEP:
  - req=1 and sleep_req=0 -> WAKE, cnt<=0.
  - Otherwise stay in SLEEP.
- WAKE:
  - sleep_req=1 -> SLEEP (abort, no wake_ack).
  - Else if cnt==WAKE_CYCLES-1 -> RUN, wake_ack<=1.
  - Else cnt<=cnt+1.
  - req dropping during WAKE does not abort; the block enters RUN, then moves to IDLE.
- RUN:
  - sleep_req=1 -> SLEEP.
  - Else req=0 -> IDLE, cnt<=0.
  - Else stay in RUN.
- IDLE:
  - sleep_req=1 -> SLEEP.
  - Else req=1 -> RUN directly: no warm-up, wake_ack stays 0.
  - Else if cnt==IDLE_CYCLES-1 -> SLEEP.
  - Else cnt<=cnt+1.
- Latency:
  - req rising in SLEEP at edge k: WAKE at k+1, RUN/enable=1 at k+1+WAKE_CYCLES.
  - req falling in RUN: enable=0 one edge later.
- Counter:
  - Unsigned, CNT_W bits, cleared on every state entry.
  - Never wraps; it is only compared, never advanced past its terminal value.
- Reset asserted mid-operation:
  - Immediate return to SLEEP values. The clock gate closes asynchronously, so the downstream domain stops cleanly.
  - After release, a new req is required and the full WAKE sequence runs.
- Illegal state encodings cannot occur (2-bit, all four used). The default branch goes to SLEEP.

Decomposition:
- Shared package pwr_pkg:
  - state encodings (PWR_SLEEP=2'b00, PWR_WAKE=2'b01, PWR_RUN=2'b10, PWR_IDLE=2'b11)
  - default IDLE_CYCLES/WAKE_CYCLES constants
  - so that the downstream FSM, monitors and benches decode pwr_state identically.
- One natural sub-module, pwr_cycle_timer:
  - loadable clear, increment, terminal-compare counter with a runtime terminal value.
  - Reused for the WAKE and IDLE windows and by other power blocks.
- The FSM and output decode stay in pwr_mode_ctrl.

Test Plan (IDLE_CYCLES=8, WAKE_CYCLES=3, 10 ns clock):
1. reset=0 at time 0, then pulse reset=0 between edges while in RUN -> all outputs immediately enable=0, clk_gate_en=0, wake_ack=0, pwr_state=00, with no clock edge needed.
2. Release reset, req=1 before edge 0 -> pwr_state=01 and clk_gate_en=1 after edge 1. WAKE holds through edges 2-3. Edge 4 gives pwr_state=10, enable=1, wake_ack=1 for exactly one cycle (0 after edge 5).
3. In RUN drop req and hold low -> IDLE (pwr_state=11, enable=0, clk_gate_en=1) after next edge. SLEEP (pwr_state=00, clk_gate_en=0) exactly 8 edges after entering IDLE.
4. In IDLE reassert req after 4 cycles -> RUN on the next edge, enable=1, wake_ack stays 0, no WAKE visit. A second req drop restarts the idle count from 0 (8 full cycles to SLEEP).
5. sleep_req=1 with req=1 during the second WAKE cycle -> SLEEP next edge, no wake_ack. Holding both high keeps pwr_state=00. Dropping sleep_req then runs the full 3-cycle WAKE.
6. sleep_req=1 for one cycle in RUN with req=1 -> SLEEP next edge, enable=0, clk_gate_en=0. Re-wake takes 1+3 edges to enable=1.
